mix_columns_seq: RTL and testbench
==================================

// Module: mix_columns_seq
// PURPOSE
//  Forward AES MixColumns engine for the encryption datapath; the counterpart of the decryption InvMixColumns helper.
//  Takes a 128-bit AES state over a valid/ready handshake and mixes it column by column, COLS_PER_CYC columns per clock.
//  Returns the mixed state over a second valid/ready handshake.
//  Sits between ShiftRows and AddRoundKey in each encryption round.
// PARAMETERS
//  COLS_PER_CYC  1  columns mixed per clock; legal values 1, 2, 4; compute latency NCYC = 4/COLS_PER_CYC
// PORTS
//  clk        in   1    rising-edge clock
//  rst_n      in   1    asynchronous active-low reset
//  in_valid   in   1    in_data is valid
//  in_ready   out  1    engine can accept a state
//  in_data    in   128  state; column c = bits [127-32c -: 32]; row 0 is the MSB byte of each column
//  out_valid  out  1    out_data holds the mixed state
//  out_ready  in   1    downstream accepts out_data
//  out_data   out  128  mixed state, same column/byte layout as in_data
// BEHAVIOUR
//  - Clocking: one clock (clk); reset rst_n is asynchronous and active-low.
//  - Reset values:
//    - FSM state = IDLE, column counter = 0, out_valid = 0, out_data = 0, working register = 0.
//    - in_ready = 1 after the first clk edge following reset deassertion.
//  - FSM states: IDLE, CALC, DONE.
//    - IDLE: in_ready=1. When in_valid, latch in_data into the working register; counter=0; go to CALC.
//    - CALC: in_ready=0. Each cycle, replace columns [cnt .. cnt+COLS_PER_CYC-1] with their mixed values
//      and add COLS_PER_CYC to cnt. After the NCYC-th CALC cycle, go to DONE.
//    - DONE: out_valid=1; out_data is the working register, held stable until out_ready.
//      - in_ready = out_ready in DONE.
//      - out_ready && in_valid: latch the new state and go to CALC (back-to-back; no IDLE bubble).
//      - out_ready && !in_valid: go to IDLE.
//  - Latency: a state accepted at edge T gives out_valid=1 in the cycle after edge T+NCYC.
//    Throughput: one state per NCYC+1 cycles.
//  - Column math over GF(2^8) (x^8+x^4+x^3+x+1): xt(b) = {b[6:0],1'b0} ^ (b[7] ? 8'h1b : 8'h00).
//    - r0' = xt(a0)^xt(a1)^a1^a2^a3
//    - r1' = a0^xt(a1)^xt(a2)^a2^a3
//    - r2' = a0^a1^xt(a2)^xt(a3)^a3
//    - r3' = xt(a0)^a0^a1^a2^xt(a3)
//  - Per-byte math is pure 8-bit combinational logic; no lookup tables.
//  - in_valid while in CALC is ignored; the input is not consumed until in_ready=1.
//  - out_valid never drops without out_ready; out_data never changes while out_valid=1 && !out_ready.
//  - rst_n asserted mid-CALC or mid-DONE: the state in flight is discarded and all outputs take their reset values immediately.
//  - Counter wraps to 0 on entry to CALC; it never exceeds 4-COLS_PER_CYC.
// CONFIGURATION
//  - MIXCOL_LAST_ROUND_EN defined:
//    - Adds input port last_rnd (1 bit), sampled with the in_valid/in_ready handshake.
//    - When last_rnd=1, the state passes through unmixed, with identical latency and handshake (supports AES final round).
//  - MIXCOL_LAST_ROUND_EN undefined: the last_rnd port is absent and every state is mixed.
// TESTING
//  - FIPS-197 vector: in_data=db135345_f20a225c_01010101_c6c6c6c6 -> out_data=8e4da1bc_9fdc589d_01010101_c6c6c6c6,
//    out_valid exactly NCYC+1 cycles after acceptance.
//  - Second vector: in_data=d4d4d4d5_2d26314c_00000000_ffffffff -> out_data=d5d5d7d6_4d7ebdf8_00000000_ffffffff.
//  - Back-to-back: two states offered with out_ready=1 -> second accepted in the same cycle the first is delivered;
//    results in order.
//  - Backpressure: out_ready=0 for 10 cycles -> out_valid and out_data stable, in_ready=0; then out_ready=1 -> one transfer only.
//  - Reset mid-CALC: rst_n low at CALC cycle 2 -> out_valid=0, out_data=0 at once; no output of the aborted state
//    after reset release.
//  - Round trip: random states through this block, then the InvMixColumns helper -> original state;
//    with MIXCOL_LAST_ROUND_EN and last_rnd=1 -> out_data==in_data.

Source files
------------

// File: rtl/mix_columns_seq_if.sv
// Handshake bundle for the sequential MixColumns engine.
// Input side:  in_valid/in_ready/in_data (plus last_rnd when MIXCOL_LAST_ROUND_EN is defined).
// Output side: out_valid/out_ready/out_data.
// A transfer happens on a rising clk edge where valid and ready are both 1.
// A valid, once raised, holds its data stable until that transfer.
interface mix_columns_seq_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
`ifdef MIXCOL_LAST_ROUND_EN
    logic         last_rnd;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    // Producer of states / consumer of results
    modport master (
        output in_valid,
        output in_data,
`ifdef MIXCOL_LAST_ROUND_EN
        output last_rnd,
`endif
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    // The engine itself
    modport slave (
        input  in_valid,
        input  in_data,
`ifdef MIXCOL_LAST_ROUND_EN
        input  last_rnd,
`endif
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/mix_columns_seq.sv
// Forward AES MixColumns engine, COLS_PER_CYC columns mixed per clock.
// A state is latched into a working register, mixed in place over
// NCYC = 4/COLS_PER_CYC CALC cycles, then presented on out_data until taken.
// Optional feature macro: MIXCOL_LAST_ROUND_EN (adds last_rnd; when set the
// state passes through unmixed with unchanged latency and handshake).
// fsm_state exposes the FSM encoding (0=IDLE, 1=CALC, 2=DONE) for checkers.
module mix_columns_seq #(
    parameter int COLS_PER_CYC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    mix_columns_seq_if.slave  bus,
    output logic [1:0]        fsm_state
);

    generate
        if (COLS_PER_CYC != 1 && COLS_PER_CYC != 2 && COLS_PER_CYC != 4) begin : g_bad_cols
            $error("mix_columns_seq: COLS_PER_CYC must be 1, 2 or 4");
        end
    endgenerate

    // Counter step and the counter value of the final CALC cycle (2-bit wrap intended).
    localparam logic [1:0] STEP = 2'(COLS_PER_CYC);
    localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYC);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state;
    logic [1:0]   cnt;
    logic [127:0] work;
    logic [127:0] work_mix;
    logic         out_valid_q;
    logic         rdy_q;      // low in reset, high from the first edge after release
    logic [1:0]   col;
    logic         accept;
`ifdef MIXCOL_LAST_ROUND_EN
    logic         last_q;
`endif

    // GF(2^8) multiply by x modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One column; row 0 is the most significant byte
    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] r0, r1, r2, r3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        r0 = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        r1 = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        r2 = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        r3 = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        return {r0, r1, r2, r3};
    endfunction

    // in_ready is 1 in IDLE (once out of reset) and follows out_ready in DONE,
    // which lets a new state enter in the same edge the previous one leaves.
    assign bus.in_ready  = ((state == IDLE) && rdy_q) || ((state == DONE) && bus.out_ready);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = work;
    assign fsm_state     = state;
    assign accept        = bus.in_valid && bus.in_ready;

    // Next working-register value: columns cnt .. cnt+COLS_PER_CYC-1 replaced by their mix.
    // Column c lives at bits [127-32c -: 32], i.e. [(3-c)*32 +: 32].
    always_comb begin
        work_mix = work;
        col      = cnt;
        for (int k = 0; k < COLS_PER_CYC; k++) begin
            col = cnt + 2'(k);
            work_mix[(3 - int'(col)) * 32 +: 32] = mix_col(work[(3 - int'(col)) * 32 +: 32]);
        end
`ifdef MIXCOL_LAST_ROUND_EN
        if (last_q) begin
            work_mix = work;
        end
`endif
    end

    // Control FSM with registered out_valid; reset discards any state in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 2'd0;
            work        <= 128'd0;
            out_valid_q <= 1'b0;
            rdy_q       <= 1'b0;
`ifdef MIXCOL_LAST_ROUND_EN
            last_q      <= 1'b0;
`endif
        end else begin
            rdy_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (accept) begin
                        work  <= bus.in_data;
                        cnt   <= 2'd0;
                        state <= CALC;
`ifdef MIXCOL_LAST_ROUND_EN
                        last_q <= bus.last_rnd;
`endif
                    end
                end
                CALC: begin
                    work <= work_mix;
                    cnt  <= cnt + STEP;
                    if (cnt == LAST) begin
                        cnt         <= 2'd0;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (bus.in_valid) begin
                            work  <= bus.in_data;
                            cnt   <= 2'd0;
                            state <= CALC;
`ifdef MIXCOL_LAST_ROUND_EN
                            last_q <= bus.last_rnd;
`endif
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state       <= IDLE;
                    cnt         <= 2'd0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Self-checking bench for mix_columns_seq (COLS_PER_CYC = 1, NCYC = 4).
// Directed FIPS-197 and hand-computed vectors, latency, back-to-back,
// backpressure, reset mid-CALC and an InvMixColumns round trip.
module tb_mix_columns_seq;
    localparam int COLS = 1;
    localparam int NCYC = 4 / COLS;

    logic       clk;
    logic       rst_n;
    logic [1:0] fsm_state;

    mix_columns_seq_if bus ();

    mix_columns_seq #(.COLS_PER_CYC(COLS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [127:0] exp_q[$];
    logic [127:0] src_q[$];
    bit           rt_q[$];
    int           acc_cyc_q[$];

    logic [127:0] drv_exp;
    logic [127:0] drv_src;
    bit           drv_rt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        total_cnt++;
        if (act !== req) begin
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end else begin
            pass_cnt++;
        end
    endtask

    // ---------------- inverse model for the round trip ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[(3 - c) * 32 + 24 +: 8];
            a1 = s[(3 - c) * 32 + 16 +: 8];
            a2 = s[(3 - c) * 32 + 8 +: 8];
            a3 = s[(3 - c) * 32 +: 8];
            r[(3 - c) * 32 + 24 +: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            r[(3 - c) * 32 + 16 +: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            r[(3 - c) * 32 + 8 +: 8]  = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            r[(3 - c) * 32 +: 8]      = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return r;
    endfunction

    // ---------------- acceptance monitor: pushes expectations ----------------
    always @(negedge clk) begin
        if (rst_n && bus.in_valid && bus.in_ready) begin
            exp_q.push_back(drv_exp);
            src_q.push_back(drv_src);
            rt_q.push_back(drv_rt);
            acc_cyc_q.push_back(cyc);
        end
    end

    // ---------------- output monitor: pops and compares ----------------
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", bus.out_data, 128'hx);
            end else begin
                logic [127:0] e;
                logic [127:0] s;
                bit           rt;
                e  = exp_q.pop_front();
                s  = src_q.pop_front();
                rt = rt_q.pop_front();
                if (rt) check("round_trip", inv_mix(bus.out_data), s);
                else    check("out_data", bus.out_data, e);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic send(input logic [127:0] d, input logic [127:0] e, input bit rt, input bit lr);
        bit done;
        done = 0;
        @(posedge clk);
        #1;
        drv_exp      = e;
        drv_src      = d;
        drv_rt       = rt;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
`ifdef MIXCOL_LAST_ROUND_EN
        bus.last_rnd = lr;
`else
        if (lr) $display("note: last_rnd ignored in this build");
`endif
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (bus.in_ready) done = 1;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
`ifdef MIXCOL_LAST_ROUND_EN
        bus.last_rnd = 1'b0;
`endif
        if (!done) check("send_timeout", 128'd0, 128'd1);
    endtask

    task automatic wait_out_valid(output int n);
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (bus.out_valid) break;
            @(posedge clk);
            n++;
        end
        if (n >= 100) check("out_valid_timeout", 128'd0, 128'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [127:0] held;
        int           lat;
        int           a0, a1;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
`ifdef MIXCOL_LAST_ROUND_EN
        bus.last_rnd  = 1'b0;
`endif
        drv_exp = '0;
        drv_src = '0;
        drv_rt  = 0;

        // Reset values
        #1;
        check("rst_out_valid", 128'(bus.out_valid), 128'd0);
        check("rst_out_data", bus.out_data, 128'd0);
        check("rst_in_ready", 128'(bus.in_ready), 128'd0);
        check("rst_state", 128'(fsm_state), 128'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_reset", 128'(bus.in_ready), 128'd1);

        // FIPS-197 vector with latency measurement
        send(128'hdb135345_f20a225c_01010101_c6c6c6c6, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 0, 0);
        wait_out_valid(lat);
        check("latency_edges", 128'(lat), 128'(NCYC));
        drain();

        // Second vector and further hand-computed ones
        send(128'hd4d4d4d5_2d26314c_00000000_ffffffff, 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff, 0, 0);
        send(128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 128'h046681e5_e0cb199a_48f8d37a_2806264c, 0, 0);
        send(128'h01000000_80000000_00000000_ffffffff, 128'h02010103_1b80809b_00000000_ffffffff, 0, 0);
        drain();

        // Back-to-back: second state accepted on the edge the first is delivered
        acc_cyc_q.delete();
        send(128'hd4d4d4d5_2d26314c_00000000_ffffffff, 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff, 0, 0);
        send(128'hdb135345_f20a225c_01010101_c6c6c6c6, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 0, 0);
        drain();
        if (acc_cyc_q.size() == 2) begin
            a0 = acc_cyc_q[0];
            a1 = acc_cyc_q[1];
            check("b2b_accept_spacing", 128'(a1 - a0), 128'(NCYC + 1));
        end else begin
            check("b2b_accept_count", 128'(acc_cyc_q.size()), 128'd2);
        end

        // Backpressure: ten cycles with out_ready low
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        send(128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 128'h046681e5_e0cb199a_48f8d37a_2806264c, 0, 0);
        wait_out_valid(lat);
        held = bus.out_data;
        bus.in_valid = 1'b1;
        bus.in_data  = 128'h0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_out_valid", 128'(bus.out_valid), 128'd1);
            check("bp_out_data", bus.out_data, held);
            check("bp_in_ready", 128'(bus.in_ready), 128'd0);
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_single_transfer", 128'(bus.out_valid), 128'd0);
        check("bp_queue_empty", 128'(exp_q.size()), 128'd0);

        // Reset asserted during the second CALC cycle
        send(128'hdb135345_f20a225c_01010101_c6c6c6c6, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 0, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midcalc_out_valid", 128'(bus.out_valid), 128'd0);
        check("midcalc_out_data", bus.out_data, 128'd0);
        check("midcalc_state", 128'(fsm_state), 128'd0);
        exp_q.delete();
        src_q.delete();
        rt_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("post_reset_idle", 128'(fsm_state), 128'd0);

        // Round trip with pseudo-random states
        for (int i = 0; i < 4; i++) begin
            send({$urandom, $urandom, $urandom, $urandom}, 128'd0, 1, 0);
        end
        drain();

`ifdef MIXCOL_LAST_ROUND_EN
        // Final-round pass-through
        send(128'hdb135345_f20a225c_01010101_c6c6c6c6, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 0, 1);
        send(128'hd4d4d4d5_2d26314c_00000000_ffffffff, 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff, 0, 0);
        drain();
`endif

        check("final_queue_empty", 128'(exp_q.size()), 128'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
